psk_modulator: RTL

Parametrised successor to the single-mode BPSK carrier modulator. It accepts data words over a valid/ready handshake and serialises them into BPSK or QPSK symbols, selectable per word. For each symbol it emits an integer number of carrier periods, read from a phase-offset sine LUT. It sits between the framing/packetiser logic and the DAC interface, and outputs signed two's-complement samples with a valid strobe.

---
 rtl/psk_modulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/psk_modulator.sv
// BPSK/QPSK carrier modulator: serialises handshaked data words into symbols, each an integer
// number of carrier periods read from a phase-offset sine LUT built at elaboration.
module psk_modulator #(
  parameter int    SINE_WIDTH         = 12,
  parameter int    ADDR_WIDTH         = 8,
  parameter int    WORD_WIDTH         = 8,
  parameter int    PERIODS_PER_SYMBOL = 1,
  parameter string SINE_FILE          = "sine_value.hex"
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         en,
  input  logic                         mode,
  input  logic [WORD_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [SINE_WIDTH-1:0] out_sample,
  output logic                         out_valid,
  output logic                         out_sym_start,
  output logic                         busy
);

  localparam int D     = 1 << ADDR_WIDTH;
  localparam int SYM_W = $clog2(WORD_WIDTH + 1);
  localparam int PER_W = (PERIODS_PER_SYMBOL > 1) ? $clog2(PERIODS_PER_SYMBOL) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  if ((WORD_WIDTH % 2) != 0 || WORD_WIDTH < 2) begin : g_bad_word
    $error("psk_modulator: WORD_WIDTH must be even and >= 2");
  end
  if (PERIODS_PER_SYMBOL < 1) begin : g_bad_pps
    $error("psk_modulator: PERIODS_PER_SYMBOL must be >= 1");
  end

  function automatic logic [D*SINE_WIDTH-1:0] build_sine();
    logic [D*SINE_WIDTH-1:0] t;
    real amp;
    real v;
    int  s;
    t   = '0;
    amp = real'((1 << (SINE_WIDTH - 1)) - 1);
    for (int unsigned i = 0; i < D; i++) begin
      v = amp * $sin(6.283185307179586 * real'(i) / real'(D));
      s = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      t[i*SINE_WIDTH +: SINE_WIDTH] = s[SINE_WIDTH-1:0];
    end
    return t;
  endfunction

  localparam logic [D*SINE_WIDTH-1:0] SINE_TABLE = build_sine();

  state_t                   state;
  logic [WORD_WIDTH-1:0]    shreg;
  logic                     mode_q;
  logic [SYM_W-1:0]         symbols_left;
  logic [ADDR_WIDTH-1:0]    sample_cnt;
  logic [PER_W-1:0]         period_cnt;
  logic [ADDR_WIDTH-1:0]    offset;
  logic [ADDR_WIDTH-1:0]    lut_addr;
  logic signed [SINE_WIDTH-1:0] lut_rd;
  logic                     period_last;
  logic                     sample_last;
  logic                     word_last;
  logic                     run_en;
  logic                     accept;

  assign period_last = (period_cnt == PER_W'(PERIODS_PER_SYMBOL - 1));
  assign sample_last = (sample_cnt == '1) && period_last;
  assign word_last   = sample_last && (symbols_left == SYM_W'(1));
  assign run_en      = (state == RUN) && en;
  assign in_ready    = (state == IDLE) || (run_en && word_last);
  assign accept      = in_valid && in_ready;
  assign busy        = (state == RUN);

  // QPSK dibits are Gray-coded onto odd multiples of 45 degrees
  always_comb begin
    offset = '0;
    if (!mode_q) begin
      offset = shreg[0] ? '0 : ADDR_WIDTH'(D / 2);
    end else begin
      case (shreg[1:0])
        2'b00:   offset = ADDR_WIDTH'(D / 8);
        2'b01:   offset = ADDR_WIDTH'(3 * D / 8);
        2'b11:   offset = ADDR_WIDTH'(5 * D / 8);
        default: offset = ADDR_WIDTH'(7 * D / 8);
      endcase
    end
  end

  assign lut_addr = sample_cnt + offset;
  assign lut_rd   = SINE_TABLE[int'(lut_addr)*SINE_WIDTH +: SINE_WIDTH];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state         <= IDLE;
      shreg         <= '0;
      mode_q        <= 1'b0;
      symbols_left  <= '0;
      sample_cnt    <= '0;
      period_cnt    <= '0;
      out_sample    <= '0;
      out_valid     <= 1'b0;
      out_sym_start <= 1'b0;
    end else begin
      if (run_en) begin
        out_sample    <= lut_rd;
        out_valid     <= 1'b1;
        out_sym_start <= (sample_cnt == '0) && (period_cnt == '0);
        sample_cnt    <= sample_cnt + ADDR_WIDTH'(1);
        if (sample_cnt == '1) begin
          period_cnt <= period_last ? '0 : period_cnt + PER_W'(1);
        end
        if (sample_last) begin
          shreg        <= mode_q ? (shreg >> 2) : (shreg >> 1);
          symbols_left <= symbols_left - SYM_W'(1);
        end
        if (word_last) begin
          state <= IDLE;
        end
      end else begin
        out_valid     <= 1'b0;
        out_sym_start <= 1'b0;
        if (state == IDLE && en) begin
          out_sample <= '0;
        end
      end
      // A word-end accept overrides the return to IDLE so the next word follows without a gap
      if (accept) begin
        shreg        <= in_data;
        mode_q       <= mode;
        symbols_left <= mode ? SYM_W'(WORD_WIDTH / 2) : SYM_W'(WORD_WIDTH);
        sample_cnt   <= '0;
        period_cnt   <= '0;
        state        <= RUN;
      end
    end
  end

endmodule
